seg_scan_driver: RTL



---
 rtl/seg_scan_driver.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_scan_driver: 4-digit seven-segment scanner with dead time and        |
// | frame-aligned value latching.                          Revision: 1.0     |
// +--------------------------------------------------------------------------+
module seg_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic [15:0] value_i,
  input  logic [3:0]  dp_i,
  input  logic        load_i,
  input  logic        blank_leading_i,
  output logic [3:0]  anode_o,
  output logic [6:0]  cathode_o,
  output logic        dp_o,
  output logic [1:0]  digit_o
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD    = CW'(DEAD_CYCLES);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } slot_state_e;

  slot_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          frame_wrap;

  logic [15:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
  logic [3:0]  pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic        dirty_q, dirty_d;

  logic [3:0]  anode_q, anode_d;
  logic [6:0]  cathode_q, cathode_d;
  logic        dp_q, dp_d;
  logic [1:0]  digit_q, digit_d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Scan sequencing: the BLANK/SHOW state always describes the next cnt value.
  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    frame_wrap = 1'b0;
    if (!enable_i) begin
      cnt_d = '0;
      idx_d = 2'd0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d      = '0;
      idx_d      = idx_q + 2'd1;
      frame_wrap = (idx_q == 2'd3);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    state_d = (enable_i && (cnt_d >= DEAD)) ? ST_SHOW : ST_BLANK;
  end

  always_comb begin
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    dirty_d    = dirty_q;
    if (frame_wrap) begin
      if (load_i) begin
        pend_val_d = value_i;
        pend_dp_d  = dp_i;
        act_val_d  = value_i;
        act_dp_d   = dp_i;
        dirty_d    = 1'b0;
      end else if (dirty_q) begin
        act_val_d = pend_val_q;
        act_dp_d  = pend_dp_q;
        dirty_d   = 1'b0;
      end
    end else if (load_i) begin
      pend_val_d = value_i;
      pend_dp_d  = dp_i;
      dirty_d    = 1'b1;
    end
  end

  logic [3:0] nibble;
  logic       zero3, zero2, zero1, lead_blank;

  always_comb begin
    zero3      = (act_val_q[15:12] == 4'h0);
    zero2      = zero3 && (act_val_q[11:8] == 4'h0);
    zero1      = zero2 && (act_val_q[7:4] == 4'h0);
    nibble     = act_val_q[3:0];
    lead_blank = 1'b0;
    case (idx_q)
      2'd1: begin nibble = act_val_q[7:4];   lead_blank = zero1; end
      2'd2: begin nibble = act_val_q[11:8];  lead_blank = zero2; end
      2'd3: begin nibble = act_val_q[15:12]; lead_blank = zero3; end
      default: begin nibble = act_val_q[3:0]; lead_blank = 1'b0; end
    endcase
    lead_blank = lead_blank && blank_leading_i;
  end

  // Pins are gated by the live enable so dropping it darkens the very next cycle.
  always_comb begin
    anode_d   = 4'hF;
    cathode_d = 7'h7F;
    dp_d      = 1'b1;
    digit_d   = enable_i ? idx_q : 2'd0;
    if (enable_i && (state_q == ST_SHOW)) begin
      anode_d   = ~(4'b0001 << idx_q);
      cathode_d = lead_blank ? 7'h7F : hex7(nibble);
      dp_d      = ~act_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_BLANK;
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      pend_val_q <= 16'h0000;
      pend_dp_q  <= 4'h0;
      act_val_q  <= 16'h0000;
      act_dp_q   <= 4'h0;
      dirty_q    <= 1'b0;
      anode_q    <= 4'hF;
      cathode_q  <= 7'h7F;
      dp_q       <= 1'b1;
      digit_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      dirty_q    <= dirty_d;
      anode_q    <= anode_d;
      cathode_q  <= cathode_d;
      dp_q       <= dp_d;
      digit_q    <= digit_d;
    end
  end

  assign anode_o   = anode_q;
  assign cathode_o = cathode_q;
  assign dp_o      = dp_q;
  assign digit_o   = digit_q;

endmodule
`default_nettype wire
